// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with branch/jump/call/return and optional return-address stack (PC_SEQUENCER_RAS_EN)
module pc_sequencer #(
  parameter int               WIDTH     = 32,
  parameter int               STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic             call,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             ras_empty,
  output logic             ras_underflow
);
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_ret_pc;

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RAS_DEPTH must be a power of 2 and at least 2");
  end

  assign pc      = r_pc;
  assign pc_plus = r_pc + WIDTH'(STEP);

`ifdef PC_SEQUENCER_RAS_EN
  localparam int AW = $clog2(RAS_DEPTH);
  logic [WIDTH-1:0] r_stack [RAS_DEPTH];
  logic [AW-1:0]    r_sp;
  logic [AW:0]      r_cnt;
  logic             r_uf;
  logic [AW-1:0]    w_top;
  logic             w_pop;
  logic             w_push;

  assign w_top         = r_sp - 1'b1;
  assign ras_empty     = r_cnt == '0;
  assign ras_underflow = r_uf;
  assign w_pop         = !stall && ret && !ras_empty;
  assign w_push        = !stall && !ret && call;
  assign w_ret_pc      = ras_empty ? pc_plus : r_stack[w_top];

  // Circular stack pointer and occupancy; a full push overwrites the oldest slot
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp  <= '0;
      r_cnt <= '0;
      r_uf  <= 1'b0;
    end else begin
      r_uf <= !stall && ret && ras_empty;
      if (w_pop) begin
        r_sp  <= w_top;
        r_cnt <= r_cnt - 1'b1;
      end else if (w_push) begin
        r_sp  <= r_sp + 1'b1;
        r_cnt <= (r_cnt == (AW+1)'(RAS_DEPTH)) ? r_cnt : r_cnt + 1'b1;
      end
    end
  end

  // Return-address storage, written with the address after the call
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp] <= pc_plus;
  end
`else
  assign w_ret_pc      = pc_plus;
  assign ras_empty     = 1'b1;
  assign ras_underflow = 1'b0;
`endif

  // Next PC by priority: stall > ret > call/jmp > branch > increment
  always_comb begin
    w_pc_nxt = stall           ? r_pc       :
               ret             ? w_ret_pc   :
               (call || jmp)   ? jmp_target :
               br_taken        ? br_target  : pc_plus;
  end

  // PC register; reset wins over stall
  always_ff @(posedge clk) begin
    if (reset) r_pc <= RESET_VEC;
    else       r_pc <= w_pc_nxt;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC and target width in bits.
REQ-002 SHALL have parameter STEP, default 4, sequential increment added to the PC.
REQ-003 SHALL have parameter RESET_VEC, default 32'h00000000, PC value loaded on reset.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >=2).
REQ-005 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port stall  input  1  freeze PC and stack this cycle.
REQ-008 SHALL have port br_taken  input  1  conditional branch resolved taken.
REQ-009 SHALL have port br_target  input  WIDTH  branch destination.
REQ-010 SHALL have port jmp  input  1  unconditional jump.
REQ-011 SHALL have port call  input  1  jump plus push of return address.
REQ-012 SHALL have port jmp_target  input  WIDTH  destination for jmp and call.
REQ-013 SHALL have port ret  input  1  pop return address into PC.
REQ-014 SHALL have port pc  output  WIDTH  registered current PC.
REQ-015 SHALL have port pc_plus  output  WIDTH  combinational pc + STEP.
REQ-016 SHALL have port ras_empty  output  1  stack holds no entries.
REQ-017 SHALL have port ras_underflow  output  1  one-cycle pulse: ret issued while empty.

Function
REQ-018 SHALL compute pc_plus = (pc + STEP) mod 2^WIDTH; 32'hFFFFFFFC + 4 wraps to 0.
REQ-019 SHALL update pc on each rising clk edge by priority: reset > stall > ret > call/jmp > br_taken > increment.
REQ-020 SHALL, on stall=1, hold pc, stack contents and pointer; all other controls ignored.
REQ-021 SHALL, on ret with stack non-empty, load pc from top entry and decrement count.
REQ-022 SHALL, on ret with stack empty, load pc with pc_plus and assert ras_underflow for exactly that following cycle.
REQ-023 SHALL, on call, load pc with jmp_target and push pc_plus.
REQ-024 SHALL, on call with stack full, overwrite the oldest entry (circular), count stays RAS_DEPTH.
REQ-025 SHALL, on ret and call asserted together, execute ret only; call ignored.
REQ-026 SHALL, on jmp (no call), load pc with jmp_target; stack untouched.
REQ-027 SHALL, on br_taken alone, load pc with br_target.
REQ-028 SHALL give one-cycle latency: pc reflects a control input on the edge it is sampled.
REQ-029 SHALL drive ras_empty combinationally from count == 0.

Reset
REQ-030 SHALL, on reset=1 at a rising edge, set pc = RESET_VEC, count = 0, ras_underflow = 0, regardless of other inputs including stall.
REQ-031 SHALL, on reset mid-sequence, discard all stack entries; first post-reset ret underflows.

Configuration
REQ-032 SHALL compile the return-address stack only when macro PC_SEQUENCER_RAS_EN is defined.
REQ-033 SHALL, without PC_SEQUENCER_RAS_EN, treat call as jmp, treat ret as increment, tie ras_empty = 1 and ras_underflow = 0, and instantiate no stack storage.

Verification
REQ-034 SHALL check: reset, then 3 idle cycles -> pc = 0, 4, 8, 12.
REQ-035 SHALL check: pc=8, call jmp_target=0x100, then ret -> pc = 0x100, then 0xC; ras_empty = 1.
REQ-036 SHALL check: 5 calls (RAS_DEPTH=4) from pc 0,0x10,0x20,0x30,0x40 (targets as given), 5 rets -> returns 0x44,0x34,0x24,0x14, then underflow pulse and pc = last pc + 4.
REQ-037 SHALL check: stall=1 with br_taken=1 br_target=0x200 for 2 cycles -> pc unchanged; stack count unchanged.
REQ-038 SHALL check: jmp=1 br_taken=1 jmp_target=0x300 br_target=0x400 -> pc = 0x300; pc = 0xFFFFFFFC idle -> pc = 0.
REQ-039 SHALL check: two calls, reset, ret -> pc = 4, ras_underflow = 1 for one cycle.
